demux3_reg: RTL
===============

DEMUX3_REG -- requirements
Module: demux3_reg

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- in_data  input  4  data word to route
- in_adr  input  2  destination: 0 -> ch0, 1 -> ch1, 2 -> ch2, 3 -> illegal
- in_valid  input  1  in_data/in_adr valid this cycle
- in_ready  output  1  block accepts the word this cycle
- y0, y1, y2  output  4 each  channel data
- v0, v1, v2  output  1 each  channel holds a valid word
- r0, r1, r2  input  1 each  channel consumer accepts the word this cycle
- err  output  1  one-cycle pulse: an illegal-address word was consumed
- err_cnt  output  4  count of illegal-address words, saturating
REQ-002 There is one clock; reset is synchronous and active-low.

Function
REQ-003 Each channel k SHALL be a one-entry buffer: 4-bit data register drives yk; full flag drives vk.
REQ-004 An input transfer occurs in any cycle with in_valid=1 and in_ready=1; with in_valid=0, in_data and in_adr are ignored.
REQ-005 For in_adr=k (k in 0..2), in_ready SHALL be ~full_k | rk, combinationally.
REQ-006 For in_adr=3, in_ready SHALL be 1; the word is discarded and no channel changes.
REQ-007 Latency: a word accepted in cycle N SHALL appear on yk with vk=1 from cycle N+1.
REQ-008 Output transfer on channel k occurs when vk=1 and rk=1; full_k SHALL clear next cycle unless refilled.
REQ-009 Simultaneous drain and fill of channel k: full_k stays 1; the register takes the new word; no bubble, no loss.
REQ-010 After a drain, yk SHALL retain its last value while vk=0; consumers treat yk as don't-care when vk=0.
REQ-011 Channel k SHALL be unaffected by transfers addressed to other channels and by rj, j!=k.
REQ-012 At most one channel is written per cycle; any number of channels may drain in the same cycle.
REQ-013 A full channel with rk=0 SHALL hold yk stable; a stalled channel does not block words to other channels (in_ready is evaluated per current in_adr).
REQ-014 An accepted in_adr=3 word SHALL cause err=1 in the next cycle only; err_cnt increments by 1 in that same cycle.
REQ-015 err_cnt SHALL saturate at 15; further illegal words still pulse err.
REQ-016 Back-to-back illegal words SHALL hold err=1 for consecutive cycles, one count per word.

Reset
REQ-017 With rst_n=0 at a clock edge: y0..y2=0, v0..v2=0, err=0, err_cnt=0 from the next cycle.
REQ-018 Reset mid-operation SHALL discard all buffered words; in_ready follows REQ-005/006 from empty state once rst_n=1.
REQ-019 While rst_n=0, no input transfer is considered accepted and no err pulse is generated.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then in_data=0xA, in_adr=1, in_valid=1 for one cycle, r1=0 -> next cycle y1=0xA, v1=1, v0=v2=0; stays until r1=1, then v1=0 the following cycle.
- Channel 2 full with r2=0, present in_adr=2 -> in_ready=0; switch to in_adr=0 with 0x5 -> in_ready=1, y0=0x5 next cycle, y2 unchanged.
- Channel 0 full with 0x3, r0=1 and new word 0xC to in_adr=0 same cycle -> in_ready=1, next cycle v0=1, y0=0xC.
- 17 consecutive in_adr=3 words -> err high 17 consecutive cycles, err_cnt reaches 15 and holds, all vk remain 0.
- All three channels full, rst_n=0 for one cycle -> all vk=0, yk=0, err_cnt=0; first post-reset word to ch1 appears after one cycle.

Source files
------------

// File: rtl/demux3_reg.sv
// demux3_reg: 1-to-3 demultiplexer with a one-entry buffer per channel.
// Address 3 is illegal; such words are dropped, pulsed on err and counted.
module demux3_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic [1:0] in_adr,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic       v0,
  output logic       v1,
  output logic       v2,
  input  logic       r0,
  input  logic       r1,
  input  logic       r2,
  output logic       err,
  output logic [3:0] err_cnt
);

  logic [2:0] full_q, full_d;
  logic [3:0] y0_q, y0_d;
  logic [3:0] y1_q, y1_d;
  logic [3:0] y2_q, y2_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;

  logic [2:0] rdy;
  logic [2:0] wr;
  logic       sel_free;
  logic       acc;
  logic       bad;

  assign rdy = {r2, r1, r0};

  // Selected channel can take a word if empty or draining this cycle.
  always_comb begin
    sel_free = 1'b1;
    unique case (in_adr)
      2'd0:    sel_free = ~full_q[0] | r0;
      2'd1:    sel_free = ~full_q[1] | r1;
      2'd2:    sel_free = ~full_q[2] | r2;
      default: sel_free = 1'b1;
    endcase
  end

  assign in_ready = rst_n & sel_free;
  assign acc      = in_valid & in_ready;
  assign bad      = acc & (in_adr == 2'd3);

  always_comb begin
    wr[0] = acc & (in_adr == 2'd0);
    wr[1] = acc & (in_adr == 2'd1);
    wr[2] = acc & (in_adr == 2'd2);
  end

  always_comb begin
    full_d = wr | (full_q & ~rdy);
    y0_d   = wr[0] ? in_data : y0_q;
    y1_d   = wr[1] ? in_data : y1_q;
    y2_d   = wr[2] ? in_data : y2_q;
    err_d  = bad;
    cnt_d  = cnt_q;
    if (bad && cnt_q != 4'hF)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 3'b000;
      y0_q   <= 4'h0;
      y1_q   <= 4'h0;
      y2_q   <= 4'h0;
      err_q  <= 1'b0;
      cnt_q  <= 4'h0;
    end else begin
      full_q <= full_d;
      y0_q   <= y0_d;
      y1_q   <= y1_d;
      y2_q   <= y2_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y0      = y0_q;
  assign y1      = y1_q;
  assign y2      = y2_q;
  assign v0      = full_q[0];
  assign v1      = full_q[1];
  assign v2      = full_q[2];
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule
